br_issue_queue: RTL and testbench

Branch reservation station directly upstream of the branch functional unit. Accepts renamed branch/jump uops from dispatch and holds them in an age-ordered collapsing queue. Wakes source operands from CDB broadcasts, reads the physical register file (PRF) at issue, and issues the oldest fully-ready entry per cycle as one issue packet.

---
 rtl/br_issue_queue.sv | 182 ++++++++++++++++++
 tb/tb_br_issue_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/br_issue_queue.sv
// Branch reservation station: age-ordered collapsing queue, CDB wakeup, oldest-ready issue.
// Define BR_RS_WAKEUP_BYPASS_EN to let same-cycle CDB wakeups issue with forwarded values.
module br_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5,
    parameter int NUM_CDB   = 2,
    localparam int PKT_W    = 169 + PRF_IDX_W + ROB_IDX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [2:0]                   disp_opcode,
    input  logic [31:0]                  disp_pc,
    input  logic [31:0]                  disp_imm,
    input  logic [PRF_IDX_W-1:0]         disp_rs1_phy,
    input  logic [PRF_IDX_W-1:0]         disp_rs2_phy,
    input  logic                         disp_rs1_rdy,
    input  logic                         disp_rs2_rdy,
    input  logic [PRF_IDX_W-1:0]         disp_rd_phy,
    input  logic [4:0]                   disp_rd_arch,
    input  logic [ROB_IDX_W-1:0]         disp_rob_id,
    input  logic                         disp_pred_taken,
    input  logic [31:0]                  disp_pred_target,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*PRF_IDX_W-1:0] cdb_rd_phy,
    input  logic [NUM_CDB*32-1:0]        cdb_rd_value,
    output logic [PRF_IDX_W-1:0]         prf_rs1_phy,
    output logic [PRF_IDX_W-1:0]         prf_rs2_phy,
    input  logic [31:0]                  prf_rs1_value,
    input  logic [31:0]                  prf_rs2_value,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [PKT_W-1:0]             iss_pkt
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [31:0]          pc;
        logic [31:0]          imm;
        logic [PRF_IDX_W-1:0] rs1;
        logic [PRF_IDX_W-1:0] rs2;
        logic [PRF_IDX_W-1:0] rd_phy;
        logic [4:0]           rd_arch;
        logic [ROB_IDX_W-1:0] rob_id;
        logic                 pred_taken;
        logic [31:0]          pred_target;
    } ent_t;

    ent_t             r_ent [DEPTH];
    logic [DEPTH-1:0] r_vld, r_rdy1, r_rdy2;
    logic [CNT_W-1:0] r_cnt;

    ent_t             w_nxt_ent [DEPTH];
    logic [DEPTH-1:0] w_nxt_vld, w_nxt_rdy1, w_nxt_rdy2;
    logic [DEPTH-1:0] w_wk1, w_wk2, w_elig;
    logic             w_dwk1, w_dwk2;
    logic [IDX_W-1:0] w_sel;
    logic             w_any, w_fire, w_acc;
    logic [CNT_W-1:0] w_cnt_keep;
    logic [31:0]      w_rs1_val, w_rs2_val;
    ent_t             w_sel_ent;
    int               w_src;

    // Tag match against every valid CDB port, for stored entries and the dispatching uop.
    always_comb begin
        w_wk1  = '0;
        w_wk2  = '0;
        w_dwk1 = 1'b0;
        w_dwk2 = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W] == r_ent[i].rs1) w_wk1[i] = 1'b1;
                    if (cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W] == r_ent[i].rs2) w_wk2[i] = 1'b1;
                end
                if (cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W] == disp_rs1_phy) w_dwk1 = 1'b1;
                if (cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W] == disp_rs2_phy) w_dwk2 = 1'b1;
            end
        end
    end

`ifdef BR_RS_WAKEUP_BYPASS_EN
    assign w_elig = r_vld & (r_rdy1 | w_wk1) & (r_rdy2 | w_wk2);
`else
    assign w_elig = r_vld & r_rdy1 & r_rdy2;
`endif

    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_any = 1'b1;
                w_sel = IDX_W'(i);
            end
        end
    end

    assign w_sel_ent   = r_ent[w_sel];
    assign prf_rs1_phy = w_any ? w_sel_ent.rs1 : '0;
    assign prf_rs2_phy = w_any ? w_sel_ent.rs2 : '0;

`ifdef BR_RS_WAKEUP_BYPASS_EN
    // Ascending port scan so the highest-index port wins on duplicate tags.
    always_comb begin
        w_rs1_val = prf_rs1_value;
        w_rs2_val = prf_rs2_value;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid[k] && !r_rdy1[w_sel] &&
                cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W] == w_sel_ent.rs1)
                w_rs1_val = cdb_rd_value[k*32 +: 32];
            if (cdb_valid[k] && !r_rdy2[w_sel] &&
                cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W] == w_sel_ent.rs2)
                w_rs2_val = cdb_rd_value[k*32 +: 32];
        end
    end
`else
    logic w_unused_cdb_value;
    assign w_unused_cdb_value = ^cdb_rd_value;
    assign w_rs1_val = prf_rs1_value;
    assign w_rs2_val = prf_rs2_value;
`endif

    assign iss_valid = w_any;
    assign iss_pkt   = {w_sel_ent.opcode, w_sel_ent.pc, w_sel_ent.imm, w_rs1_val, w_rs2_val,
                        w_sel_ent.rd_phy, w_sel_ent.rd_arch, w_sel_ent.rob_id,
                        w_sel_ent.pred_taken, w_sel_ent.pred_target};

    assign w_fire     = w_any & iss_ready;
    assign disp_ready = (r_cnt < CNT_W'(DEPTH)) | w_fire;
    assign w_acc      = disp_valid & disp_ready & ~flush;
    assign w_cnt_keep = r_cnt - CNT_W'(w_fire);

    // Collapse above the fired slot, then append the new uop at the post-shift tail.
    always_comb begin
        w_src = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w_src = (w_fire && i >= int'(w_sel) && i + 1 < DEPTH) ? i + 1 : i;
            w_nxt_ent[i]  = r_ent[w_src];
            w_nxt_vld[i]  = 1'b0;
            w_nxt_rdy1[i] = r_rdy1[w_src] | w_wk1[w_src];
            w_nxt_rdy2[i] = r_rdy2[w_src] | w_wk2[w_src];
            if (i < int'(w_cnt_keep)) begin
                w_nxt_vld[i] = 1'b1;
            end else if (i == int'(w_cnt_keep) && w_acc) begin
                w_nxt_vld[i]  = 1'b1;
                w_nxt_ent[i]  = '{opcode: disp_opcode, pc: disp_pc, imm: disp_imm,
                                  rs1: disp_rs1_phy, rs2: disp_rs2_phy, rd_phy: disp_rd_phy,
                                  rd_arch: disp_rd_arch, rob_id: disp_rob_id,
                                  pred_taken: disp_pred_taken, pred_target: disp_pred_target};
                w_nxt_rdy1[i] = disp_rs1_rdy | (disp_rs1_phy == '0) | w_dwk1;
                w_nxt_rdy2[i] = disp_rs2_rdy | (disp_rs2_phy == '0) | w_dwk2;
            end else begin
                w_nxt_rdy1[i] = 1'b0;
                w_nxt_rdy2[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_vld  <= '0;
            r_rdy1 <= '0;
            r_rdy2 <= '0;
            r_cnt  <= '0;
        end else begin
            r_vld  <= w_nxt_vld;
            r_rdy1 <= w_nxt_rdy1;
            r_rdy2 <= w_nxt_rdy2;
            r_cnt  <= w_cnt_keep + CNT_W'(w_acc);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_nxt_ent[i];
    end
endmodule

// File: tb/tb_br_issue_queue.sv
// Directed bench for br_issue_queue: vector table for single-uop issue plus hand sequences.
module tb_br_issue_queue;
    localparam int P = 6, R = 5, NC = 2;

    logic          clk = 1'b0;
    logic          rst, flush, disp_valid, disp_ready;
    logic [2:0]    disp_opcode;
    logic [31:0]   disp_pc, disp_imm, disp_pred_target;
    logic [P-1:0]  disp_rs1_phy, disp_rs2_phy, disp_rd_phy;
    logic          disp_rs1_rdy, disp_rs2_rdy, disp_pred_taken;
    logic [4:0]    disp_rd_arch;
    logic [R-1:0]  disp_rob_id;
    logic [NC-1:0] cdb_valid;
    logic [NC*P-1:0]  cdb_rd_phy;
    logic [NC*32-1:0] cdb_rd_value;
    logic [P-1:0]  prf_rs1_phy, prf_rs2_phy;
    logic [31:0]   prf_rs1_value, prf_rs2_value;
    logic          iss_valid, iss_ready;
    logic [169+P+R-1:0] iss_pkt;

    typedef struct packed {
        logic [2:0] op; logic [31:0] pc, imm, v1, v2;
        logic [P-1:0] rd_phy; logic [4:0] rd_arch; logic [R-1:0] rob;
        logic pt; logic [31:0] ptgt;
    } pkt_t;
    pkt_t pkt;
    assign pkt = iss_pkt;

    logic [31:0] mem [64];
    assign prf_rs1_value = mem[prf_rs1_phy];
    assign prf_rs2_value = mem[prf_rs2_phy];

    br_issue_queue #(.DEPTH(4), .PRF_IDX_W(P), .ROB_IDX_W(R), .NUM_CDB(NC)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
        .disp_pc(disp_pc), .disp_imm(disp_imm),
        .disp_rs1_phy(disp_rs1_phy), .disp_rs2_phy(disp_rs2_phy),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rd_phy(disp_rd_phy), .disp_rd_arch(disp_rd_arch), .disp_rob_id(disp_rob_id),
        .disp_pred_taken(disp_pred_taken), .disp_pred_target(disp_pred_target),
        .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy), .cdb_rd_value(cdb_rd_value),
        .prf_rs1_phy(prf_rs1_phy), .prf_rs2_phy(prf_rs2_phy),
        .prf_rs1_value(prf_rs1_value), .prf_rs2_value(prf_rs2_value),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_pkt(iss_pkt)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        disp_valid = 0; cdb_valid = '0; cdb_rd_phy = '0; cdb_rd_value = '0;
        flush = 0; iss_ready = 0;
    endtask

    task automatic disp(input logic [2:0] op, input logic [5:0] r1, input logic k1,
                        input logic [5:0] r2, input logic k2, input logic [4:0] rob);
        disp_valid = 1; disp_opcode = op;
        disp_pc = 32'h1000 + {25'd0, rob, 2'b00}; disp_imm = 32'hFFFF_FF00 | {27'd0, rob};
        disp_rs1_phy = r1; disp_rs1_rdy = k1; disp_rs2_phy = r2; disp_rs2_rdy = k2;
        disp_rd_phy = {1'b1, rob}; disp_rd_arch = rob; disp_rob_id = rob;
        disp_pred_taken = rob[0]; disp_pred_target = 32'h2000 + {27'd0, rob};
    endtask

    task automatic cdb(input int port, input logic [5:0] tag, input logic [31:0] val);
        cdb_valid[port] = 1'b1;
        cdb_rd_phy[port*P +: P] = tag;
        cdb_rd_value[port*32 +: 32] = val;
    endtask

    task automatic chk_iss(input string nm, input logic [4:0] rob,
                           input logic [31:0] v1, input logic [31:0] v2);
        chk({nm, "_valid"}, {31'd0, iss_valid}, 32'd1);
        chk({nm, "_rob"}, {27'd0, pkt.rob}, {27'd0, rob});
        chk({nm, "_rs1v"}, pkt.v1, v1);
        chk({nm, "_rs2v"}, pkt.v2, v2);
    endtask

    typedef struct {
        logic [2:0] op; logic [5:0] r1; logic k1; logic [5:0] r2; logic k2;
        logic [4:0] rob; logic [31:0] e1, e2;
    } vec_t;
    vec_t vt [4];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h100 + i;
        mem[3] = 32'd5; mem[4] = 32'd5;
        vt[0] = '{3'd0, 6'd3,  1'b1, 6'd4,  1'b1, 5'd7,  32'd5,     32'd5};
        vt[1] = '{3'd1, 6'd0,  1'b0, 6'd10, 1'b1, 5'd3,  32'h100,   32'h10A};
        vt[2] = '{3'd6, 6'd0,  1'b0, 6'd0,  1'b0, 5'd31, 32'h100,   32'h100};
        vt[3] = '{3'd7, 6'd63, 1'b1, 6'd1,  1'b1, 5'd0,  32'h13F,   32'h101};

        idle; rst = 1;
        disp_opcode = 0; disp_pc = 0; disp_imm = 0; disp_rs1_phy = 0; disp_rs2_phy = 0;
        disp_rs1_rdy = 0; disp_rs2_rdy = 0; disp_rd_phy = 0; disp_rd_arch = 0;
        disp_rob_id = 0; disp_pred_taken = 0; disp_pred_target = 0;
        tick; tick; rst = 0; #1;
        chk("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("rst_disp_ready", {31'd0, disp_ready}, 32'd1);
        chk("rst_prf_rs1", {26'd0, prf_rs1_phy}, 32'd0);
        chk("rst_prf_rs2", {26'd0, prf_rs2_phy}, 32'd0);

        // single uop dispatch -> issue next cycle -> empty
        for (int i = 0; i < 4; i++) begin
            tick; idle; iss_ready = 1;
            disp(vt[i].op, vt[i].r1, vt[i].k1, vt[i].r2, vt[i].k2, vt[i].rob);
            #1 chk("vec_pre_empty", {31'd0, iss_valid}, 32'd0);
            tick; idle; iss_ready = 1; #1;
            chk_iss("vec", vt[i].rob, vt[i].e1, vt[i].e2);
            chk("vec_op", {29'd0, pkt.op}, {29'd0, vt[i].op});
            chk("vec_pc", pkt.pc, 32'h1000 + {25'd0, vt[i].rob, 2'b00});
            chk("vec_rd_phy", {26'd0, pkt.rd_phy}, {26'd0, 1'b1, vt[i].rob});
            chk("vec_ptgt", pkt.ptgt, 32'h2000 + {27'd0, vt[i].rob});
        end
        tick; idle; #1 chk("vec_post_empty", {31'd0, iss_valid}, 32'd0);

        // late wakeup; duplicate tag on both ports, port 1 carries the real value
        idle; iss_ready = 1; disp(3'd1, 6'd7, 1'b0, 6'd4, 1'b1, 5'd5);
        tick; idle; iss_ready = 1; #1 chk("wk_wait1", {31'd0, iss_valid}, 32'd0);
        tick; idle; iss_ready = 1; cdb(0, 6'd7, 32'hDEAD); cdb(1, 6'd7, 32'h10); #1;
`ifdef BR_RS_WAKEUP_BYPASS_EN
        chk_iss("wk_byp", 5'd5, 32'h10, 32'd5);
        tick; idle; #1 chk("wk_byp_empty", {31'd0, iss_valid}, 32'd0);
`else
        chk("wk_same_cycle", {31'd0, iss_valid}, 32'd0);
        tick; idle; iss_ready = 1; #1 chk_iss("wk_next", 5'd5, 32'h107, 32'd5);
        tick; idle; #1 chk("wk_empty", {31'd0, iss_valid}, 32'd0);
`endif

        // A..D, only C ready; D wakes while shifting down
        idle; disp(3'd0, 6'd20, 1'b0, 6'd0, 1'b0, 5'd1);
        tick; disp(3'd0, 6'd21, 1'b0, 6'd0, 1'b0, 5'd2);
        tick; disp(3'd0, 6'd3,  1'b1, 6'd4, 1'b1, 5'd3);
        tick; disp(3'd0, 6'd22, 1'b0, 6'd0, 1'b0, 5'd4);
        tick; idle; #1;
        chk("abcd_full_ready", {31'd0, disp_ready}, 32'd0);
        chk_iss("abcd_c", 5'd3, 32'd5, 32'd5);
        iss_ready = 1; cdb(1, 6'd22, 32'h0);
        tick; idle; #1 chk_iss("abcd_d_first", 5'd4, 32'h116, 32'h100);
        cdb(0, 6'd21, 32'h0);
        tick; idle; iss_ready = 1; #1 chk_iss("abcd_b", 5'd2, 32'h115, 32'h100);
        tick; idle; iss_ready = 1; #1 chk_iss("abcd_d", 5'd4, 32'h116, 32'h100);
        tick; idle; #1 chk("abcd_a_waits", {31'd0, iss_valid}, 32'd0);
        chk("abcd_ready", {31'd0, disp_ready}, 32'd1);
        flush = 1; tick; idle;

        // full queue: rejected dispatch, then fire + accept in one cycle
        disp(3'd2, 6'd3, 1'b1, 6'd4, 1'b1, 5'd8);
        tick; disp(3'd2, 6'd30, 1'b0, 6'd0, 1'b0, 5'd9);
        tick; disp(3'd2, 6'd31, 1'b0, 6'd0, 1'b0, 5'd10);
        tick; disp(3'd2, 6'd32, 1'b0, 6'd0, 1'b0, 5'd11);
        tick; idle; disp(3'd2, 6'd1, 1'b1, 6'd2, 1'b1, 5'd12); #1;
        chk("full_ready", {31'd0, disp_ready}, 32'd0);
        tick; idle; #1 chk("full_still", {31'd0, disp_ready}, 32'd0);
        chk("full_oldest", {27'd0, pkt.rob}, 32'd8);
        iss_ready = 1; disp(3'd2, 6'd1, 1'b1, 6'd2, 1'b1, 5'd12); #1;
        chk("full_fire_ready", {31'd0, disp_ready}, 32'd1);
        tick; idle; #1;
        chk("full_cnt4", {31'd0, disp_ready}, 32'd0);
        chk_iss("full_new", 5'd12, 32'h101, 32'h102);
        iss_ready = 1;
        tick; idle; #1 chk("full_cnt3", {31'd0, disp_ready}, 32'd1);
        chk("full_rest_blocked", {31'd0, iss_valid}, 32'd0);

        // flush with three valid entries and a same-cycle dispatch
        flush = 1; disp(3'd3, 6'd3, 1'b1, 6'd4, 1'b1, 5'd13);
        tick; idle; #1;
        chk("flush_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("flush_disp_ready", {31'd0, disp_ready}, 32'd1);
        cdb(0, 6'd30, 32'h0); cdb(1, 6'd31, 32'h0);
        tick; idle; #1 chk("flush_gone", {31'd0, iss_valid}, 32'd0);

        // dispatch-cycle wakeup
        iss_ready = 1; disp(3'd4, 6'd9, 1'b0, 6'd4, 1'b1, 5'd14); cdb(0, 6'd9, 32'h0);
        tick; idle; iss_ready = 1; #1 chk_iss("dwk", 5'd14, 32'h109, 32'd5);
        tick; idle; #1 chk("dwk_empty", {31'd0, iss_valid}, 32'd0);

        // reset mid-operation
        disp(3'd5, 6'd3, 1'b1, 6'd4, 1'b1, 5'd15);
        tick; idle; #1 chk("mid_pre", {31'd0, iss_valid}, 32'd1);
        rst = 1; tick; rst = 0; #1;
        chk("mid_rst_valid", {31'd0, iss_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, disp_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
